// File: rtl/lcd_frame_scheduler_if.sv
// Writer and LCD-controller signals of the frame scheduler, bundled as one port.
// master = writer plus LCD controller side, slave = the scheduler itself.
interface lcd_frame_scheduler_if;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       commit;
    logic [6:0] char_address;
    logic [7:0] lcd_data_out;
    logic       update_n;
    logic       busy;
    logic       timeout_err;

    modport master (
        output wr_en, wr_addr, wr_data, commit, char_address,
        input  wr_ready, lcd_data_out, update_n, busy, timeout_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, char_address,
        output wr_ready, lcd_data_out, update_n, busy, timeout_err
    );
endinterface

// File: rtl/lcd_frame_scheduler.sv
// Double-buffered 32-character LCD frame store with a refresh handshake,
// a request timeout and an enforced minimum gap between refreshes.
module lcd_frame_scheduler #(
    parameter int         CHARS       = 32,
    parameter int         MIN_GAP     = 50000,
    parameter int         REQ_TIMEOUT = 2000000,
    parameter logic [7:0] FILL        = 8'h20
) (
    input  logic                 clk,
    input  logic                 reset,
    lcd_frame_scheduler_if.slave bus
);
    localparam int             GW        = $clog2(MIN_GAP + 1);
    localparam int             TW        = $clog2(REQ_TIMEOUT + 1);
    localparam logic [GW-1:0]  GAP_LAST  = GW'(MIN_GAP - 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(REQ_TIMEOUT - 1);
    localparam logic [4:0]     COPY_LAST = 5'(CHARS - 1);
    localparam logic [6:0]     CHARS_CA  = 7'(CHARS);

    typedef enum logic [2:0] {IDLE, COPY, REQ, XFER, GAP} state_t;

    state_t        state_reg, state_next;
    logic          bank_sel_reg;
    logic          pending_reg;
    logic [4:0]    copy_idx_reg;
    logic [GW-1:0] gap_cnt_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic          timeout_err_reg;
    logic          update_n_reg;
    logic [6:0]    ca_s1_reg, ca_s2_reg, ca_prev_reg, ca_q_reg;
    logic [7:0]    bank_mem [2][CHARS];

    logic swap;
    logic timeout_hit;
    logic wr_ready;
    logic wr_fire;
    logic commit_fire;
    logic back_sel;

    // char_address comes from a slow divided domain: synchronise, then only
    // accept a value once it has been seen on two consecutive samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ca_s1_reg   <= '0;
            ca_s2_reg   <= '0;
            ca_prev_reg <= '0;
            ca_q_reg    <= '0;
        end else begin
            ca_s1_reg   <= bus.char_address;
            ca_s2_reg   <= ca_s1_reg;
            ca_prev_reg <= ca_s2_reg;
            if (ca_s2_reg == ca_prev_reg)
                ca_q_reg <= ca_s2_reg;
        end
    end

    assign back_sel    = ~bank_sel_reg;
    assign wr_ready    = !pending_reg && (state_reg != COPY);
    assign wr_fire     = bus.wr_en && wr_ready;
    assign commit_fire = bus.commit && wr_ready;

    always_comb begin
        state_next  = state_reg;
        swap        = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pending_reg) begin
                    swap       = 1'b1;
                    state_next = COPY;
                end
            end
            COPY: begin
                if (copy_idx_reg == COPY_LAST)
                    state_next = REQ;
            end
            REQ: begin
                if (ca_q_reg != 7'd0) begin
                    state_next = XFER;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            XFER: begin
                if (ca_q_reg == 7'd0)
                    state_next = GAP;
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            bank_sel_reg    <= 1'b0;
            pending_reg     <= 1'b0;
            copy_idx_reg    <= '0;
            gap_cnt_reg     <= '0;
            tmo_cnt_reg     <= '0;
            timeout_err_reg <= 1'b0;
            update_n_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (swap)
                bank_sel_reg <= ~bank_sel_reg;
            if (swap)
                pending_reg <= 1'b0;
            else if (commit_fire)
                pending_reg <= 1'b1;
            copy_idx_reg <= (state_reg == COPY) ? copy_idx_reg + 5'd1 : 5'd0;
            // Both counters hold at their terminal value instead of wrapping.
            if (state_reg != GAP)
                gap_cnt_reg <= '0;
            else if (gap_cnt_reg != GAP_LAST)
                gap_cnt_reg <= gap_cnt_reg + 1'b1;
            if (state_reg != REQ)
                tmo_cnt_reg <= '0;
            else if (tmo_cnt_reg != TMO_LAST)
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            if (timeout_hit)
                timeout_err_reg <= 1'b1;
            // Registered so the strobe rises on the same edge that leaves REQ.
            update_n_reg <= (state_next != REQ);
        end
    end

    // Writer edits land in the back bank; COPY refreshes the back bank from
    // the freshly swapped front so incremental edits start from what is shown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < CHARS; i++)
                    bank_mem[b][i] <= FILL;
        end else if (wr_fire) begin
            bank_mem[back_sel][bus.wr_addr] <= bus.wr_data;
        end else if (state_reg == COPY) begin
            bank_mem[back_sel][copy_idx_reg] <= bank_mem[bank_sel_reg][copy_idx_reg];
        end
    end

    assign bus.lcd_data_out = (bus.char_address < CHARS_CA)
                              ? bank_mem[bank_sel_reg][bus.char_address[4:0]]
                              : FILL;
    assign bus.wr_ready     = wr_ready;
    assign bus.update_n     = update_n_reg;
    assign bus.busy         = (state_reg != IDLE);
    assign bus.timeout_err  = timeout_err_reg;
endmodule
